// File: rtl/branch_cond_unit.sv
// Branch condition resolver: waits for in-flight flag writers to commit, then
// evaluates the condition code against the N/Z/V flags and produces the next PC.
module branch_cond_unit #(
  parameter int PC_W  = 16,
  parameter int OFF_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [2:0]       br_ccc,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  pc_plus2,
  input  logic [2:0]       flag_in,
  input  logic             flag_pend,
  output logic             br_stall,
  output logic             br_done,
  output logic             br_taken,
  output logic [PC_W-1:0]  br_target,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             latch_en;

  logic [2:0]       ccc_reg;
  logic [OFF_W-1:0] off_reg;
  logic [PC_W-1:0]  pc_reg;

  logic             done_reg;
  logic             taken_reg;
  logic [PC_W-1:0]  target_reg;
  logic             flush_reg;
  logic [CNT_W-1:0] taken_cnt_reg;
  logic [CNT_W-1:0] total_cnt_reg;

  logic             cond_true;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  target_taken;

  // Unconditional branches do not depend on flags, so they skip the hazard wait.
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (br_valid) begin
          latch_en   = 1'b1;
          state_next = (br_ccc == 3'b111 || !flag_pend) ? EVAL : WAIT;
        end
      end
      WAIT:    if (!flag_pend) state_next = EVAL;
      EVAL:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags are {n, z, v}.
  always_comb begin
    cond_true = 1'b0;
    case (ccc_reg)
      3'b000:  cond_true = !flag_in[1];
      3'b001:  cond_true = flag_in[1];
      3'b010:  cond_true = !flag_in[1] && !flag_in[2];
      3'b011:  cond_true = flag_in[2];
      3'b100:  cond_true = flag_in[1] || !flag_in[2];
      3'b101:  cond_true = flag_in[2] || flag_in[1];
      3'b110:  cond_true = flag_in[0];
      default: cond_true = 1'b1;
    endcase
  end

  // Word offset: sign-extend, then scale to bytes; overflow wraps silently.
  assign off_ext      = {{(PC_W-OFF_W){off_reg[OFF_W-1]}}, off_reg};
  assign target_taken = pc_reg + {off_ext[PC_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ccc_reg       <= '0;
      off_reg       <= '0;
      pc_reg        <= '0;
      done_reg      <= 1'b0;
      taken_reg     <= 1'b0;
      target_reg    <= '0;
      flush_reg     <= 1'b0;
      taken_cnt_reg <= '0;
      total_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        ccc_reg <= br_ccc;
        off_reg <= br_off;
        pc_reg  <= pc_plus2;
      end
      if (state_reg == EVAL) begin
        done_reg   <= 1'b1;
        taken_reg  <= cond_true;
        target_reg <= cond_true ? target_taken : pc_reg;
        flush_reg  <= cond_true;
      end else begin
        done_reg  <= 1'b0;
        flush_reg <= 1'b0;
      end
      if (state_reg == DONE) begin
        total_cnt_reg <= total_cnt_reg + 1'b1;
        if (taken_reg) taken_cnt_reg <= taken_cnt_reg + 1'b1;
      end
    end
  end

  assign br_stall  = (state_reg == WAIT) || (state_reg == EVAL) ||
                     ((state_reg == IDLE) && br_valid);
  assign br_done   = done_reg;
  assign br_taken  = taken_reg;
  assign br_target = target_reg;
  assign flush     = flush_reg;
  assign taken_cnt = taken_cnt_reg;
  assign total_cnt = total_cnt_reg;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Randomized self-checking bench for branch_cond_unit with a transaction-level
// reference model (condition table, wrapped target arithmetic, latency, counters).
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic [8:0]  br_off;
  logic [15:0] pc_plus2;
  logic [2:0]  flag_in;
  logic        flag_pend;
  logic        br_stall, br_done, br_taken, flush;
  logic [15:0] br_target, taken_cnt, total_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_total = 0;
  int          m_taken = 0;
  logic        m_last_taken = 1'b0;
  logic [15:0] m_last_target = 16'h0;

  branch_cond_unit #(.PC_W(16), .OFF_W(9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ccc(br_ccc),
    .br_off(br_off), .pc_plus2(pc_plus2), .flag_in(flag_in),
    .flag_pend(flag_pend), .br_stall(br_stall), .br_done(br_done),
    .br_taken(br_taken), .br_target(br_target), .flush(flush),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_taken(input int ccc, input logic [2:0] f);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_counters();
    check("taken_cnt", 32'(taken_cnt), 32'(m_taken % 65536));
    check("total_cnt", 32'(total_cnt), 32'(m_total % 65536));
  endtask

  // One branch: pend = number of cycles (from the request cycle) with flag_pend=1.
  task automatic run_br(input int ccc, input int off, input logic [15:0] pc,
                        input logic [2:0] flags, input int pend);
    bit          exp_t;
    logic [15:0] exp_tgt;
    int          lat;
    exp_t   = model_taken(ccc, flags);
    exp_tgt = exp_t ? pc + 16'(2 * off) : pc;
    lat     = (ccc == 7 || pend == 0) ? 2 : pend + 2;
    for (int cyc = 0; cyc <= lat; cyc++) begin
      @(negedge clk);
      br_valid  = (cyc < lat);
      br_ccc    = 3'(ccc);
      br_off    = 9'(off);
      pc_plus2  = pc;
      flag_pend = (cyc < pend);
      flag_in   = (cyc >= pend) ? flags : ~flags;
      #1;
      if (cyc == 0) begin
        check_counters();
        check("hold_taken", 32'(br_taken), 32'(m_last_taken));
        check("hold_target", 32'(br_target), 32'(m_last_target));
      end
      check("stall", 32'(br_stall), 32'(cyc < lat));
      check("done", 32'(br_done), 32'(cyc == lat));
      check("flush", 32'(flush), 32'((cyc == lat) && exp_t));
      if (cyc == lat) begin
        check("taken", 32'(br_taken), 32'(exp_t));
        check("target", 32'(br_target), 32'(exp_tgt));
      end
    end
    $display("[TB] br ccc=%0d off=%0d pc=%h flags=%b pend=%0d -> taken=%0d target=%h",
             ccc, off, pc, flags, pend, exp_t, exp_tgt);
    m_total++;
    if (exp_t) m_taken++;
    m_last_taken  = exp_t;
    m_last_target = exp_tgt;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_stall"}, 32'(br_stall), 32'(0));
    check({tag, "_done"}, 32'(br_done), 32'(0));
    check({tag, "_taken"}, 32'(br_taken), 32'(0));
    check({tag, "_target"}, 32'(br_target), 32'(0));
    check({tag, "_flush"}, 32'(flush), 32'(0));
    check_counters();
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_ccc = 3'd0; br_off = 9'd0;
    pc_plus2 = 16'h0; flag_in = 3'd0; flag_pend = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_br(1, 4, 16'h0100, 3'b010, 0);   // EQ taken, +4 words
    run_br(0, 4, 16'h0200, 3'b010, 0);   // NE not taken
    run_br(2, 7, 16'h0300, 3'b000, 3);   // GT behind a 3-cycle hazard
    run_br(7, -2, 16'h0002, 3'b000, 3);  // unconditional ignores hazard, wraps

    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        run_br(c, int'($urandom_range(0, 511)) - 256, 16'($urandom), 3'(f), 0);

    for (int i = 0; i < 60; i++)
      run_br(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)) - 256,
             16'($urandom), 3'($urandom), int'($urandom_range(0, 4)));

    // Reset while a branch is parked in WAIT: it must vanish without a trace.
    @(negedge clk);
    br_valid = 1'b1; br_ccc = 3'd1; flag_pend = 1'b1;
    @(negedge clk);
    #1;
    check("wait_stall", 32'(br_stall), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; br_valid = 1'b0; flag_pend = 1'b0;
    m_total = 0; m_taken = 0; m_last_taken = 1'b0; m_last_target = 16'h0;
    #1;
    check_idle_zero("rst_wait");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_nodone", 32'(br_done), 32'(0));
    end
    $display("[TB] reset during WAIT applied");

    run_br(6, 10, 16'h1000, 3'b001, 1);
    run_br(3, -5, 16'h2000, 3'b000, 2);
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    check_counters();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the processor's N/Z/V flag register. Accepts one branch request at a time from decode, with its 3-bit condition code. Waits until no older flag-writing ALU instruction is still in flight, then samples the committed flags, resolves taken/not-taken and computes the next PC. Drives the pipeline stall, redirect target and flush, and keeps taken/total branch counters for performance monitoring.

## Interface
Parameters:
- PC_W, 16, program counter width
- OFF_W, 9, branch offset width; signed, in instructions (words)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- br_valid  in  1  branch instruction present in decode; held by upstream while br_stall=1
- br_ccc  in  3  condition code
- br_off  in  OFF_W  signed word offset
- pc_plus2  in  PC_W  address of the instruction after the branch
- flag_in  in  3  committed flags {n,z,v} from the flag register; bit2=n, bit1=z, bit0=v
- flag_pend  in  1  an older flag-writing instruction has not yet committed its flags
- br_stall  out  1  hold fetch/decode
- br_done  out  1  one-cycle pulse; result outputs valid
- br_taken  out  1  resolved direction
- br_target  out  PC_W  next PC; pc_plus2 when not taken
- flush  out  1  equals br_done & br_taken; squash the younger fetched instruction
- taken_cnt  out  CNT_W  count of resolved taken branches
- total_cnt  out  CNT_W  count of resolved branches

## Operation
- States: IDLE, WAIT, EVAL, DONE.
- IDLE:
  - On br_valid, latch br_ccc, br_off and pc_plus2.
  - If br_ccc=111 or flag_pend=0, go to EVAL; otherwise go to WAIT.
- WAIT:
  - Stay while flag_pend=1.
  - When flag_pend=0, go to EVAL. Flags are never sampled in WAIT.
- EVAL: sample flag_in, evaluate the latched condition, register the outputs, go to DONE.
- DONE:
  - br_done=1, br_taken/br_target valid, flush=br_taken.
  - Increment the counters, then go to IDLE.
- Conditions:
  - 000 NE: z=0
  - 001 EQ: z=1
  - 010 GT: z=0 and n=0
  - 011 LT: n=1
  - 100 GTE: z=1 or n=0
  - 101 LTE: n=1 or z=1
  - 110 OV: v=1
  - 111 always taken
- Target when taken: pc_plus2 + (sign_extend(br_off) << 1), truncated to PC_W. Wrap-around is modulo 2^PC_W and is not flagged.
- br_valid is ignored in WAIT, EVAL and DONE; it is sampled only in IDLE.
- Counters wrap at 2^CNT_W. total_cnt increments on every DONE. taken_cnt increments on DONE only when br_taken=1.

## Timing
- Reset values: state IDLE; br_stall, br_done, br_taken, flush = 0; br_target = 0; taken_cnt, total_cnt = 0.
- Reset asserted in any state: IDLE next cycle with all of the above values. The in-flight branch is dropped and not counted.
- br_stall = (state is WAIT or EVAL) or (state is IDLE and br_valid). It is low in DONE, so decode advances the cycle the result is presented.
- Latency, no hazard: br_valid seen at cycle t → EVAL at t+1 → br_done at t+2.
- Latency, hazard: each additional cycle of flag_pend=1 after t adds one WAIT cycle.
- flag_pend dropping in cycle k means flag_in is final in cycle k. EVAL is at k+1 and samples flag_in in that cycle.
- br_done, br_taken, br_target and flush are registered. br_taken and br_target hold their values after DONE until the next EVAL; br_done and flush are 0 outside DONE.
- Back-to-back: a new br_valid is accepted no earlier than the IDLE cycle after DONE, giving a minimum period of 3 cycles per branch.

## Test plan
- Reset, then EQ (001) with flag_in=010, flag_pend=0, pc_plus2=0x0100, br_off=+4 → br_done at t+2, br_taken=1, br_target=0x0108, flush=1, taken_cnt=1, total_cnt=1.
- NE (000) with flag_in=010 → br_taken=0, br_target=pc_plus2, flush=0; total_cnt increments and taken_cnt does not.
- GT (010) with flag_pend=1 for 3 cycles; flag_in changes from 100 to 000 in the cycle flag_pend drops → br_stall high throughout WAIT, result taken, br_done 5 cycles after the request.
- Unconditional (111) with flag_pend=1 → no WAIT state, br_done at t+2, taken. Negative offset: pc_plus2=0x0002, br_off=-2 → br_target=0xFFFE (wrap).
- Sweep all 8 codes against all 8 flag_in values → br_taken matches the condition list in every case; OV (110) is taken only when flag_in bit0=1.
- Assert rst_n=0 during WAIT → IDLE next cycle, all outputs 0, counters 0, no br_done pulse.
